// File: rtl/snes_map_arbiter.sv
// snes_map_arbiter
//   Registered channel selection between the SNES core bus and NCH
//   coprocessor/mapper channels. Channel 0 is the fallback mapper.
//   A channel change drains the outgoing channel's ROM/BSRAM cycle
//   (bounded by DRAIN_MAX), inserts one idle blanking cycle, then hands
//   the buses to the new channel.
//
// Ports
//   mclk, rst_n          master clock, asynchronous active-low reset
//   map_active[NCH]      per-channel request (lowest set bit above 0 wins)
//   ch_*                 flattened per-channel buses, channel k in slice k
//   di, irq_n            CPU data / IRQ from the selected channel
//   rom_*, bsram_*       ROM and BSRAM buses from the selected channel
//   sel_idx              currently selected channel
//   switching            high while draining or blanking
//   multi_err            sticky: more than one request bit seen
//   drain_timeout        sticky: a switch was forced before the channel idled
//   turbo_allow          ~TURBO_BLOCK[sel_idx]
module snes_map_arbiter #(
  parameter int NCH = 8,
  parameter int ROM_AW = 24,
  parameter int BSRAM_AW = 20,
  parameter int DRAIN_MAX = 15,
  parameter logic [NCH-1:0] TURBO_BLOCK = '0
) (
  input  logic                      mclk,
  input  logic                      rst_n,
  input  logic [NCH-1:0]            map_active,
  input  logic [8*NCH-1:0]          ch_do,
  input  logic [NCH-1:0]            ch_irq_n,
  input  logic [ROM_AW*NCH-1:0]     ch_rom_addr,
  input  logic [16*NCH-1:0]         ch_rom_d,
  input  logic [NCH-1:0]            ch_rom_ce_n,
  input  logic [NCH-1:0]            ch_rom_oe_n,
  input  logic [NCH-1:0]            ch_rom_we_n,
  input  logic [NCH-1:0]            ch_rom_word,
  input  logic [BSRAM_AW*NCH-1:0]   ch_bsram_addr,
  input  logic [8*NCH-1:0]          ch_bsram_d,
  input  logic [NCH-1:0]            ch_bsram_ce_n,
  input  logic [NCH-1:0]            ch_bsram_oe_n,
  input  logic [NCH-1:0]            ch_bsram_we_n,
  output logic [7:0]                di,
  output logic                      irq_n,
  output logic [ROM_AW-1:0]         rom_addr,
  output logic [15:0]               rom_d,
  output logic                      rom_ce_n,
  output logic                      rom_oe_n,
  output logic                      rom_we_n,
  output logic                      rom_word,
  output logic [BSRAM_AW-1:0]       bsram_addr,
  output logic [7:0]                bsram_d,
  output logic                      bsram_ce_n,
  output logic                      bsram_oe_n,
  output logic                      bsram_we_n,
  output logic [$clog2(NCH)-1:0]    sel_idx,
  output logic                      switching,
  output logic                      multi_err,
  output logic                      drain_timeout,
  output logic                      turbo_allow
);

  localparam int SW = $clog2(NCH);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

  localparam logic [7:0] DMAX = 8'(DRAIN_MAX);

  // Per-channel views of the flattened buses
  logic [7:0]          do_a        [NCH];
  logic [ROM_AW-1:0]   rom_addr_a  [NCH];
  logic [15:0]         rom_d_a     [NCH];
  logic [BSRAM_AW-1:0] bsram_addr_a[NCH];
  logic [7:0]          bsram_d_a   [NCH];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
    assign do_a[gi]         = ch_do[gi*8 +: 8];
    assign rom_addr_a[gi]   = ch_rom_addr[gi*ROM_AW +: ROM_AW];
    assign rom_d_a[gi]      = ch_rom_d[gi*16 +: 16];
    assign bsram_addr_a[gi] = ch_bsram_addr[gi*BSRAM_AW +: BSRAM_AW];
    assign bsram_d_a[gi]    = ch_bsram_d[gi*8 +: 8];
  end

  logic [1:0]    state_reg, state_next;
  logic [SW-1:0] sel_idx_reg, sel_idx_next;
  logic [SW-1:0] target_reg, target_next;
  logic [7:0]    cnt_reg, cnt_next;
  logic          multi_err_reg, multi_err_next;
  logic          drain_timeout_reg, drain_timeout_next;

  logic [SW-1:0] req_idx;
  logic [SW-1:0] sel_safe;
  logic          multi_hot;
  logic          ch_idle;
  logic          cnt_last;
  logic          blank;

  // Lowest set request bit above channel 0; channel 0 when none is set.
  always_comb begin
    req_idx = '0;
    for (int i = NCH - 1; i >= 1; i--) begin
      if (map_active[i]) begin
        req_idx = SW'(i);
      end
    end
  end

  // x & (x-1) is non-zero exactly when two or more bits are set
  assign multi_hot = |(map_active & (map_active - {{(NCH-1){1'b0}}, 1'b1}));

  // Indices past the last channel (non-power-of-two NCH) fall back to 0
  assign sel_safe = (int'(sel_idx_reg) < NCH) ? sel_idx_reg : '0;

  assign ch_idle = ch_rom_ce_n[sel_safe] & ch_bsram_ce_n[sel_safe] &
                   ch_rom_we_n[sel_safe] & ch_bsram_we_n[sel_safe];

  // The counter reaches DRAIN_MAX on this DRAIN cycle, so a stuck channel
  // spends exactly DRAIN_MAX cycles in DRAIN.
  assign cnt_last = (cnt_reg >= (DMAX - 8'd1));

  assign blank = (state_reg == ST_BLANK);

  always_comb begin
    state_next         = state_reg;
    sel_idx_next       = sel_idx_reg;
    target_next        = target_reg;
    cnt_next           = cnt_reg;
    multi_err_next     = multi_err_reg | multi_hot;
    drain_timeout_next = drain_timeout_reg;
    case (state_reg)
      ST_RUN: begin
        cnt_next = '0;
        if (req_idx != sel_idx_reg) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cnt_reg != DMAX) begin
          cnt_next = cnt_reg + 8'd1;
        end
        if (req_idx == sel_idx_reg) begin
          state_next = ST_RUN;
        end else if (ch_idle || cnt_last) begin
          state_next  = ST_BLANK;
          target_next = req_idx;
          if (!ch_idle) begin
            drain_timeout_next = 1'b1;
          end
        end
      end
      ST_BLANK: begin
        // Requests are not looked at here; RUN re-evaluates them
        sel_idx_next = target_reg;
        state_next   = ST_RUN;
      end
      default: begin
        state_next = ST_BLANK;
      end
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= ST_BLANK;
      sel_idx_reg       <= '0;
      target_reg        <= '0;
      cnt_reg           <= '0;
      multi_err_reg     <= 1'b0;
      drain_timeout_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      sel_idx_reg       <= sel_idx_next;
      target_reg        <= target_next;
      cnt_reg           <= cnt_next;
      multi_err_reg     <= multi_err_next;
      drain_timeout_reg <= drain_timeout_next;
    end
  end

  // Output mux: zero-latency pass-through of the selected channel, idle
  // values while blanking so no mixed-channel strobe or IRQ leaks out.
  always_comb begin
    di         = 8'h00;
    irq_n      = 1'b1;
    rom_addr   = '0;
    rom_d      = 16'h0000;
    rom_ce_n   = 1'b1;
    rom_oe_n   = 1'b1;
    rom_we_n   = 1'b1;
    rom_word   = 1'b0;
    bsram_addr = '0;
    bsram_d    = 8'h00;
    bsram_ce_n = 1'b1;
    bsram_oe_n = 1'b1;
    bsram_we_n = 1'b1;
    if (!blank) begin
      di         = do_a[sel_safe];
      irq_n      = ch_irq_n[sel_safe];
      rom_addr   = rom_addr_a[sel_safe];
      rom_d      = rom_d_a[sel_safe];
      rom_ce_n   = ch_rom_ce_n[sel_safe];
      rom_oe_n   = ch_rom_oe_n[sel_safe];
      rom_we_n   = ch_rom_we_n[sel_safe];
      rom_word   = ch_rom_word[sel_safe];
      bsram_addr = bsram_addr_a[sel_safe];
      bsram_d    = bsram_d_a[sel_safe];
      bsram_ce_n = ch_bsram_ce_n[sel_safe];
      bsram_oe_n = ch_bsram_oe_n[sel_safe];
      bsram_we_n = ch_bsram_we_n[sel_safe];
    end
  end

  assign sel_idx       = sel_idx_reg;
  assign switching     = (state_reg != ST_RUN);
  assign multi_err     = multi_err_reg;
  assign drain_timeout = drain_timeout_reg;
  assign turbo_allow   = ~TURBO_BLOCK[sel_safe];

endmodule

// File: tb/tb_snes_map_arbiter.sv
// Directed bench for snes_map_arbiter (NCH=8, DRAIN_MAX=15,
// TURBO_BLOCK=8'b0000_1010). Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge.
module tb_snes_map_arbiter;

  localparam int NCH = 8;
  localparam int ROM_AW = 24;
  localparam int BSRAM_AW = 20;

  logic                    mclk = 1'b0;
  logic                    rst_n;
  logic [NCH-1:0]          map_active;
  logic [8*NCH-1:0]        ch_do;
  logic [NCH-1:0]          ch_irq_n;
  logic [ROM_AW*NCH-1:0]   ch_rom_addr;
  logic [16*NCH-1:0]       ch_rom_d;
  logic [NCH-1:0]          ch_rom_ce_n, ch_rom_oe_n, ch_rom_we_n, ch_rom_word;
  logic [BSRAM_AW*NCH-1:0] ch_bsram_addr;
  logic [8*NCH-1:0]        ch_bsram_d;
  logic [NCH-1:0]          ch_bsram_ce_n, ch_bsram_oe_n, ch_bsram_we_n;
  logic [7:0]              di;
  logic                    irq_n;
  logic [ROM_AW-1:0]       rom_addr;
  logic [15:0]             rom_d;
  logic                    rom_ce_n, rom_oe_n, rom_we_n, rom_word;
  logic [BSRAM_AW-1:0]     bsram_addr;
  logic [7:0]              bsram_d;
  logic                    bsram_ce_n, bsram_oe_n, bsram_we_n;
  logic [2:0]              sel_idx;
  logic                    switching, multi_err, drain_timeout, turbo_allow;

  int checks = 0;
  int failures = 0;

  always #5 mclk = ~mclk;

  snes_map_arbiter #(
    .NCH(NCH), .ROM_AW(ROM_AW), .BSRAM_AW(BSRAM_AW),
    .DRAIN_MAX(15), .TURBO_BLOCK(8'b0000_1010)
  ) dut (
    .mclk(mclk), .rst_n(rst_n), .map_active(map_active),
    .ch_do(ch_do), .ch_irq_n(ch_irq_n),
    .ch_rom_addr(ch_rom_addr), .ch_rom_d(ch_rom_d),
    .ch_rom_ce_n(ch_rom_ce_n), .ch_rom_oe_n(ch_rom_oe_n),
    .ch_rom_we_n(ch_rom_we_n), .ch_rom_word(ch_rom_word),
    .ch_bsram_addr(ch_bsram_addr), .ch_bsram_d(ch_bsram_d),
    .ch_bsram_ce_n(ch_bsram_ce_n), .ch_bsram_oe_n(ch_bsram_oe_n),
    .ch_bsram_we_n(ch_bsram_we_n),
    .di(di), .irq_n(irq_n), .rom_addr(rom_addr), .rom_d(rom_d),
    .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n), .rom_we_n(rom_we_n),
    .rom_word(rom_word), .bsram_addr(bsram_addr), .bsram_d(bsram_d),
    .bsram_ce_n(bsram_ce_n), .bsram_oe_n(bsram_oe_n), .bsram_we_n(bsram_we_n),
    .sel_idx(sel_idx), .switching(switching), .multi_err(multi_err),
    .drain_timeout(drain_timeout), .turbo_allow(turbo_allow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_edge();
    @(posedge mclk);
    #1;
  endtask

  // Hard stop in case the sequence ever stalls
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    map_active = '0;
    ch_irq_n = 8'b1111_1011;       // channel 2 asserts IRQ
    ch_rom_ce_n = '1;
    ch_rom_oe_n = 8'b1111_1011;    // channel 2 drives ROM oe
    ch_rom_we_n = '1;
    ch_rom_word = 8'b0000_0100;
    ch_bsram_ce_n = '1;
    ch_bsram_oe_n = '1;
    ch_bsram_we_n = '1;
    for (int k = 0; k < NCH; k++) begin
      ch_do[k*8 +: 8]                 = 8'h10 + 8'(k);
      ch_rom_addr[k*ROM_AW +: ROM_AW] = 24'hA00000 + 24'(k) * 24'h011111;
      ch_rom_d[k*16 +: 16]            = 16'hC000 + 16'(k);
      ch_bsram_addr[k*BSRAM_AW +: BSRAM_AW] = 20'h50000 + 20'(k);
      ch_bsram_d[k*8 +: 8]            = 8'h80 + 8'(k);
    end

    // ---- reset held ----
    $display("step reset_hold");
    repeat (2) @(negedge mclk);
    chk("rst_rom_ce_n", 32'(rom_ce_n), 32'd1);
    chk("rst_rom_we_n", 32'(rom_we_n), 32'd1);
    chk("rst_bsram_ce_n", 32'(bsram_ce_n), 32'd1);
    chk("rst_di", 32'(di), 32'h00);
    chk("rst_sel", 32'(sel_idx), 32'd0);
    chk("rst_switching", 32'(switching), 32'd1);
    chk("rst_turbo", 32'(turbo_allow), 32'd1);
    chk("rst_multi", 32'(multi_err), 32'd0);

    // ---- release: one idle cycle then channel 0 ----
    $display("step reset_release");
    drive_edge();
    rst_n = 1'b1;
    @(negedge mclk);
    chk("rel_blank_di", 32'(di), 32'h00);
    @(negedge mclk);
    chk("rel_di_ch0", 32'(di), 32'h10);
    chk("rel_switching", 32'(switching), 32'd0);

    // ---- clean switch to channel 2 ----
    $display("step clean_switch ch2");
    drive_edge();
    map_active = 8'b0000_0100;
    @(negedge mclk);
    chk("cs_c0_switching", 32'(switching), 32'd0);
    @(negedge mclk);
    chk("cs_c1_switching", 32'(switching), 32'd1);
    chk("cs_c1_di", 32'(di), 32'h10);
    @(negedge mclk);
    chk("cs_c2_switching", 32'(switching), 32'd1);
    chk("cs_c2_di_blank", 32'(di), 32'h00);
    chk("cs_c2_irq_blank", 32'(irq_n), 32'd1);
    @(negedge mclk);
    chk("cs_sel", 32'(sel_idx), 32'd2);
    chk("cs_rom_addr", 32'(rom_addr), 32'hA22222);
    chk("cs_irq", 32'(irq_n), 32'd0);
    chk("cs_rom_oe_n", 32'(rom_oe_n), 32'd0);
    chk("cs_rom_word", 32'(rom_word), 32'd1);
    chk("cs_switching", 32'(switching), 32'd0);
    chk("cs_turbo_ch2", 32'(turbo_allow), 32'd1);

    // ---- drain wait: channel 2 busy 5 cycles, request channel 3 ----
    $display("step drain_wait ch3");
    drive_edge();
    ch_rom_ce_n[2] = 1'b0;
    map_active = 8'b0000_1000;
    @(negedge mclk);
    for (int i = 1; i <= 4; i++) begin
      @(negedge mclk);
      chk("dw_sel_busy", 32'(sel_idx), 32'd2);
    end
    chk("dw_rom_ce_follow", 32'(rom_ce_n), 32'd0);
    drive_edge();
    ch_rom_ce_n[2] = 1'b1;
    @(negedge mclk);
    chk("dw_idle_sel", 32'(sel_idx), 32'd2);
    chk("dw_idle_sw", 32'(switching), 32'd1);
    @(negedge mclk);
    chk("dw_blank_di", 32'(di), 32'h00);
    chk("dw_blank_sel", 32'(sel_idx), 32'd2);
    @(negedge mclk);
    chk("dw_sel", 32'(sel_idx), 32'd3);
    chk("dw_di", 32'(di), 32'h13);
    chk("dw_timeout", 32'(drain_timeout), 32'd0);
    chk("turbo_ch3", 32'(turbo_allow), 32'd0);

    // ---- timeout: channel 3 bsram_ce_n stuck, request channel 5 ----
    $display("step timeout ch5");
    drive_edge();
    ch_bsram_ce_n[3] = 1'b0;
    map_active = 8'b0010_0000;
    @(negedge mclk);
    repeat (15) @(negedge mclk);
    chk("to_c15_sel", 32'(sel_idx), 32'd3);
    chk("to_c15_bsram_ce", 32'(bsram_ce_n), 32'd0);
    chk("to_c15_flag", 32'(drain_timeout), 32'd0);
    @(negedge mclk);
    chk("to_blank_bsram_ce", 32'(bsram_ce_n), 32'd1);
    chk("to_blank_flag", 32'(drain_timeout), 32'd1);
    @(negedge mclk);
    chk("to_sel", 32'(sel_idx), 32'd5);
    chk("to_switching", 32'(switching), 32'd0);
    chk("to_bsram_addr", 32'(bsram_addr), 32'h50005);
    ch_bsram_ce_n[3] = 1'b1;

    // ---- back to channel 0 (channel 5 idle) ----
    $display("step return ch0");
    drive_edge();
    map_active = '0;
    repeat (4) @(negedge mclk);
    chk("ret_sel", 32'(sel_idx), 32'd0);
    chk("ret_timeout_sticky", 32'(drain_timeout), 32'd1);

    // ---- abort: request channel 4 while channel 0 busy, then drop it ----
    $display("step abort ch4");
    drive_edge();
    ch_rom_we_n[0] = 1'b0;
    map_active = 8'b0001_0000;
    repeat (3) @(negedge mclk);
    chk("ab_draining", 32'(switching), 32'd1);
    drive_edge();
    map_active = '0;
    @(negedge mclk);
    chk("ab_c3_no_blank_di", 32'(di), 32'h10);
    @(negedge mclk);
    chk("ab_run", 32'(switching), 32'd0);
    chk("ab_sel", 32'(sel_idx), 32'd0);
    chk("ab_di", 32'(di), 32'h10);
    ch_rom_we_n[0] = 1'b1;

    // ---- multi-hot ----
    $display("step multi_hot");
    drive_edge();
    map_active = 8'b0010_0010;
    @(negedge mclk);
    @(negedge mclk);
    chk("mh_flag", 32'(multi_err), 32'd1);
    repeat (2) @(negedge mclk);
    chk("mh_sel", 32'(sel_idx), 32'd1);
    chk("mh_di", 32'(di), 32'h11);
    chk("turbo_ch1", 32'(turbo_allow), 32'd0);
    drive_edge();
    map_active = 8'b0000_0010;
    repeat (3) @(negedge mclk);
    chk("mh_sticky", 32'(multi_err), 32'd1);
    chk("mh_sel_hold", 32'(sel_idx), 32'd1);

    // ---- reset during DRAIN aborts the switch ----
    $display("step reset_mid_drain");
    drive_edge();
    ch_rom_ce_n[1] = 1'b0;
    map_active = 8'b0100_0000;
    repeat (3) @(negedge mclk);
    chk("rd_draining_sel", 32'(sel_idx), 32'd1);
    drive_edge();
    rst_n = 1'b0;
    @(negedge mclk);
    chk("rd_sel", 32'(sel_idx), 32'd0);
    chk("rd_multi", 32'(multi_err), 32'd0);
    chk("rd_timeout", 32'(drain_timeout), 32'd0);
    chk("rd_rom_ce_idle", 32'(rom_ce_n), 32'd1);
    drive_edge();
    rst_n = 1'b1;
    map_active = '0;
    ch_rom_ce_n[1] = 1'b1;
    @(negedge mclk);
    chk("rd_rel_blank", 32'(di), 32'h00);
    @(negedge mclk);
    chk("rd_rel_ch0", 32'(di), 32'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
